rom_rd_arbiter: RTL and testbench
=================================

# rom_rd_arbiter

Round-robin read arbiter and burst sequencer sitting in front of the single-port, fixed-latency read ROM. It accepts burst read requests (start address + length) from two requesters, grants one at a time, and drives the ROM read port with one address per cycle. Returned data goes to a shared response bus, tagged with requester ID and last-beat flag. Used by the linked-list verification environment to share one ROM image between two traversal engines.

## Interface

- ADDR_WD, 8, ROM address width
- DATA_WD, 8, ROM data width
- DATA_DEPTH, 48, ROM entries; burst addresses wrap modulo DATA_DEPTH
- LEN_WD, 4, burst length field width (max burst 2^LEN_WD-1)

- clk  in  1  single clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- req_vld  in  2  per-requester request valid; bit i = requester i
- req_addr0 / req_addr1  in  ADDR_WD  burst start address, must be < DATA_DEPTH
- req_len0 / req_len1  in  LEN_WD  beats to read
- req_rdy  out  2  per-requester accept; transfer when req_vld[i] & req_rdy[i]
- rom_rd_vld  out  1  ROM read strobe (registered)
- rom_rd_addr  out  ADDR_WD  ROM read address (registered)
- rom_rd_data  in  DATA_WD  ROM read data, 1 cycle after strobe
- rom_rd_data_out_vld  in  1  ROM data valid
- rsp_vld  out  1  response beat valid (registered)
- rsp_data  out  DATA_WD  response data
- rsp_id  out  1  requester owning the beat
- rsp_last  out  1  final beat of the burst
- busy  out  1  burst in progress or beats outstanding

## Operation

- States: IDLE, BURST.
- IDLE: req_rdy[i] = 1 only for the arbitration winner among asserted req_vld bits; at most one bit high. req_rdy is combinational from req_vld, state and priority pointer.
- Arbitration: 1-bit priority pointer, reset to 0. When both request, pointer wins. After any accept, pointer = other requester. Single requester always wins.
- Accept with len>0: latch addr, len, id; go to BURST. Accept with len=0: accepted, no ROM reads, no response, pointer still rotates, stay IDLE.
- BURST: each cycle drive rom_rd_vld=1, rom_rd_addr=current address; address increments, wrapping DATA_DEPTH-1 -> 0; remaining count decrements. Issuing the last beat returns to IDLE the next cycle.
- Outside BURST: rom_rd_vld=0, rom_rd_addr held at last value.
- Tag pipeline: id and last flag of each issued beat delayed to align with rom_rd_data_out_vld. On ROM valid: rsp_vld=1, rsp_data=rom_rd_data, rsp_id, rsp_last registered. Otherwise rsp_vld=0, rsp_data=0, rsp_id=0, rsp_last=0.
- rom_rd_data_out_vld with no beat outstanding: ignored, no rsp_vld.
- No response backpressure; consumers must accept every beat.
- busy = state==BURST or any beat in tag pipeline.
- Requester must hold req_vld/addr/len stable until accepted; deasserting before accept is allowed (request withdrawn).

## Timing

- Reset (reset_n=0 at an edge): state IDLE, pointer 0, req_rdy follows IDLE rule next cycle, rom_rd_vld=0, rom_rd_addr=0, rsp_vld=0, rsp_data=0, rsp_id=0, rsp_last=0, busy=0. Reset mid-burst discards burst and outstanding beats; no further rsp_vld.
- Accept in cycle T: rom_rd_vld high cycles T+1..T+len; ROM data T+2..T+len+1; rsp_vld high T+3..T+len+2, rsp_last on T+len+2.
- Back-to-back: earliest next accept is cycle T+len+1 (one IDLE cycle between bursts); ROM strobes have a one-cycle gap.
- Response beats of consecutive bursts never interleave.

## Test plan

- Bench ROM model with DATA_DEPTH=20 and standard image (0:0x09, 1:0x3F, 2:0xCC, 3:0xCC, 4:0xCD, 19:0x16).
- Req0 addr=1 len=3 alone -> rom_rd_addr 1,2,3 on T+1..T+3; rsp_data 0x3F,0xCC,0xCC on T+3..T+5, rsp_id=0, rsp_last only on 0xCC at T+5.
- Both requesting from reset (req0 addr=0 len=1, req1 addr=4 len=1) -> req0 granted first (rsp 0x09 id 0), req1 at T+2 (rsp 0xCD id 1); then both re-request -> req0 granted first again (pointer moved to 0 after req1 accept).
- Req1 addr=19 len=3 -> addresses 19,0,1; rsp 0x16,0x09,0x3F, last on 0x3F.
- Req0 len=0 -> req_rdy[0] pulse, no rom_rd_vld, no rsp_vld, pointer moves to 1.
- Reset asserted during cycle T+2 of an len=5 burst -> next cycle all outputs at reset values, no rsp_vld afterward, busy=0; new request after reset served normally.

Source files
------------

// File: rtl/rom_rd_arbiter.sv
// ---------------------------------------------------------------------------
// rom_rd_arbiter
//
// Round-robin read arbiter and burst sequencer in front of a single-port,
// fixed-latency (1 cycle) read ROM. Two requesters post burst reads (start
// address + length). One burst is granted at a time. The ROM is driven with
// one address per cycle, and returned data is put on a shared response bus
// tagged with the owning requester and a last-beat flag.
//
// Handshake: a request transfers on a rising clk edge where
// req_vld[i] & req_rdy[i] == 1. req_rdy is combinational from req_vld, the
// FSM state and the priority pointer. A requester keeps its addr/len stable
// while req_vld is high and unaccepted, but it may drop req_vld to withdraw.
// The response bus has no backpressure: every rsp_vld beat must be taken.
//
// Ports:
//   clk                  single clock, all logic on posedge
//   reset_n              synchronous active-low reset
//   req_vld[1:0]         per-requester request valid
//   req_addr0/1          burst start address (< DATA_DEPTH)
//   req_len0/1           number of beats (0 = accepted, no reads)
//   req_rdy[1:0]         per-requester accept (at most one bit high)
//   rom_rd_vld           ROM read strobe (registered)
//   rom_rd_addr          ROM read address (registered, held when idle)
//   rom_rd_data          ROM read data, one cycle after the strobe
//   rom_rd_data_out_vld  ROM data valid
//   rsp_vld              response beat valid (registered)
//   rsp_data             response data (zero when rsp_vld is low)
//   rsp_id               requester owning the beat
//   rsp_last             final beat of the burst
//   busy                 burst in progress or beats still outstanding
//   dbg_state            FSM state (0 = IDLE, 1 = BURST)
// ---------------------------------------------------------------------------
module rom_rd_arbiter #(
  parameter int ADDR_WD    = 8,
  parameter int DATA_WD    = 8,
  parameter int DATA_DEPTH = 48,
  parameter int LEN_WD     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_vld,
  input  logic [ADDR_WD-1:0] req_addr0,
  input  logic [ADDR_WD-1:0] req_addr1,
  input  logic [LEN_WD-1:0]  req_len0,
  input  logic [LEN_WD-1:0]  req_len1,
  output logic [1:0]         req_rdy,
  output logic               rom_rd_vld,
  output logic [ADDR_WD-1:0] rom_rd_addr,
  input  logic [DATA_WD-1:0] rom_rd_data,
  input  logic               rom_rd_data_out_vld,
  output logic               rsp_vld,
  output logic [DATA_WD-1:0] rsp_data,
  output logic               rsp_id,
  output logic               rsp_last,
  output logic               busy,
  output logic               dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state;
  logic               ptr;        // requester that wins a tie
  logic [ADDR_WD-1:0] next_addr;  // address of the next beat to issue
  logic [LEN_WD-1:0]  remaining;  // beats still to issue after the current one
  logic               burst_id;   // owner of the burst in flight

  // Tag of the beat currently on the ROM strobe (aligned with rom_rd_vld).
  logic               issue_id;
  logic               issue_last;

  // Tag of the beat whose data the ROM is returning this cycle.
  logic               pend_vld;
  logic               pend_id;
  logic               pend_last;

  // Arbitration and accept decode.
  logic               win1;
  logic               acc;
  logic               acc_id;
  logic [ADDR_WD-1:0] acc_addr;
  logic [LEN_WD-1:0]  acc_len;

  // Next address with wrap at the end of the ROM image.
  function automatic logic [ADDR_WD-1:0] wrap_inc(input logic [ADDR_WD-1:0] a);
    if (a == ADDR_WD'(DATA_DEPTH - 1)) begin
      return '0;
    end
    return a + 1'b1;
  endfunction

  // Requester 1 wins when it is the only one asking, or when both ask and
  // the pointer favours it. Grants are only offered in IDLE.
  always_comb begin
    win1     = 1'b0;
    req_rdy  = 2'b00;
    acc      = 1'b0;
    acc_id   = 1'b0;
    acc_addr = req_addr0;
    acc_len  = req_len0;
    if (state == IDLE) begin
      win1    = req_vld[1] & (~req_vld[0] | ptr);
      req_rdy = {win1, req_vld[0] & ~win1};
    end
    acc    = |(req_vld & req_rdy);
    acc_id = req_rdy[1];
    if (acc_id) begin
      acc_addr = req_addr1;
      acc_len  = req_len1;
    end
  end

  // Burst sequencer. The accepting edge already issues the first beat, so
  // the strobe is high exactly while the FSM sits in BURST. The edge that
  // ends the last beat returns to IDLE, which leaves one idle cycle between
  // bursts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      next_addr   <= '0;
      remaining   <= '0;
      burst_id    <= 1'b0;
      rom_rd_vld  <= 1'b0;
      rom_rd_addr <= '0;
      issue_id    <= 1'b0;
      issue_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rom_rd_vld <= 1'b0;
          if (acc) begin
            // A zero-length accept still rotates the pointer.
            ptr <= ~acc_id;
            if (acc_len != '0) begin
              state       <= BURST;
              burst_id    <= acc_id;
              rom_rd_vld  <= 1'b1;
              rom_rd_addr <= acc_addr;
              next_addr   <= wrap_inc(acc_addr);
              remaining   <= acc_len - 1'b1;
              issue_id    <= acc_id;
              issue_last  <= (acc_len == LEN_WD'(1));
            end
          end
        end
        BURST: begin
          if (remaining == '0) begin
            state      <= IDLE;
            rom_rd_vld <= 1'b0;
          end else begin
            rom_rd_vld  <= 1'b1;
            rom_rd_addr <= next_addr;
            next_addr   <= wrap_inc(next_addr);
            remaining   <= remaining - 1'b1;
            issue_id    <= burst_id;
            issue_last  <= (remaining == LEN_WD'(1));
          end
        end
        default: begin
          state      <= IDLE;
          rom_rd_vld <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline plus response register. ROM data valid that has no
  // matching outstanding beat (e.g. a strobe issued just before a reset)
  // is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_vld  <= 1'b0;
      pend_id   <= 1'b0;
      pend_last <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      pend_vld  <= rom_rd_vld;
      pend_id   <= issue_id;
      pend_last <= issue_last;
      if (rom_rd_data_out_vld && pend_vld) begin
        rsp_vld  <= 1'b1;
        rsp_data <= rom_rd_data;
        rsp_id   <= pend_id;
        rsp_last <= pend_last;
      end else begin
        rsp_vld  <= 1'b0;
        rsp_data <= '0;
        rsp_id   <= 1'b0;
        rsp_last <= 1'b0;
      end
    end
  end

  // The strobe is only high in BURST, so the stages after it are covered by
  // the state plus the pending tag.
  assign busy      = (state == BURST) | pend_vld;
  assign dbg_state = state;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_rd_arbiter
//
// Directed bench for rom_rd_arbiter with a 20-entry ROM model. The ROM
// returns data and a valid one cycle after each strobe. Each scenario task
// steps cycle by cycle. Inputs are driven at posedge+1, and outputs are
// checked against hand-computed values at posedge+1. The combinational
// req_rdy is checked at posedge+2.
// ---------------------------------------------------------------------------
module tb_rom_rd_arbiter;

  localparam int ADDR_WD    = 8;
  localparam int DATA_WD    = 8;
  localparam int DATA_DEPTH = 20;
  localparam int LEN_WD     = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [1:0]         req_vld;
  logic [ADDR_WD-1:0] req_addr0;
  logic [ADDR_WD-1:0] req_addr1;
  logic [LEN_WD-1:0]  req_len0;
  logic [LEN_WD-1:0]  req_len1;
  logic [1:0]         req_rdy;
  logic               rom_rd_vld;
  logic [ADDR_WD-1:0] rom_rd_addr;
  logic [DATA_WD-1:0] rom_rd_data;
  logic               rom_rd_data_out_vld;
  logic               rsp_vld;
  logic [DATA_WD-1:0] rsp_data;
  logic               rsp_id;
  logic               rsp_last;
  logic               busy;
  logic               dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_WD-1:0] rom_mem [0:DATA_DEPTH-1];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rom_rd_arbiter #(
    .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD),
    .DATA_DEPTH(DATA_DEPTH), .LEN_WD(LEN_WD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_vld(req_vld), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_len0(req_len0), .req_len1(req_len1), .req_rdy(req_rdy),
    .rom_rd_vld(rom_rd_vld), .rom_rd_addr(rom_rd_addr),
    .rom_rd_data(rom_rd_data), .rom_rd_data_out_vld(rom_rd_data_out_vld),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_last(rsp_last), .busy(busy), .dbg_state(dbg_state)
  );

  // ROM model: one-cycle read latency, not affected by the DUT reset.
  always @(posedge clk) begin
    rom_rd_data_out_vld <= rom_rd_vld;
    if (rom_rd_addr < ADDR_WD'(DATA_DEPTH)) rom_rd_data <= rom_mem[rom_rd_addr];
    else rom_rd_data <= 8'hEE;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] a0, input logic [3:0] l0,
                       input logic [7:0] a1, input logic [3:0] l1);
    req_vld   = v;
    req_addr0 = a0;
    req_len0  = l0;
    req_addr1 = a1;
    req_len1  = l1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive(2'b00, 8'd0, 4'd0, 8'd0, 4'd0);
    tick(); tick();
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h000) begin
      n_fail++; $display("FAIL reset_rom got=%h exp=000", {rom_rd_vld, rom_rd_addr});
    end
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data, busy} !== 12'h000) begin
      n_fail++; $display("FAIL reset_rsp got=%h exp=000", {rsp_vld, rsp_id, rsp_last, rsp_data, busy});
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({req_rdy, busy, dbg_state} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle got=%b exp=0000", {req_rdy, busy, dbg_state});
    end
  endtask

  // Both requesters from reset: req0 first, then req1, then again req0.
  task automatic test_arbitration();
    drive(2'b11, 8'd0, 4'd1, 8'd4, 4'd1);                     // T
    #1;
    n_checks++;
    if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL arb_rdy_t0 got=%b exp=01", req_rdy); end
    tick();                                                   // T+1
    req_vld = 2'b10;
    #1;
    n_checks++;
    if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL arb_rdy_burst got=%b exp=00", req_rdy); end
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h100) begin
      n_fail++; $display("FAIL arb_rom0 got=%h exp=100", {rom_rd_vld, rom_rd_addr});
    end
    tick();                                                   // T+2
    #1;
    n_checks++;
    if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL arb_rdy_t2 got=%b exp=10", req_rdy); end
    tick();                                                   // T+3
    req_vld = 2'b00;
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h104) begin
      n_fail++; $display("FAIL arb_rom1 got=%h exp=104", {rom_rd_vld, rom_rd_addr});
    end
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b101_0000_1001) begin
      n_fail++; $display("FAIL arb_rsp0 got=%h exp=509", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // T+4
    n_checks++;
    if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL arb_rsp_gap got=%b exp=0", rsp_vld); end
    drive(2'b11, 8'd0, 4'd1, 8'd4, 4'd1);
    #1;
    n_checks++;
    if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL arb_rdy_again got=%b exp=01", req_rdy); end
    tick();                                                   // T+5
    req_vld = 2'b10;
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b111_1100_1101) begin
      n_fail++; $display("FAIL arb_rsp1 got=%h exp=7cd", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // T+6
    #1;
    n_checks++;
    if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL arb_rdy_t6 got=%b exp=10", req_rdy); end
    tick();                                                   // T+7
    req_vld = 2'b00;
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b101_0000_1001) begin
      n_fail++; $display("FAIL arb_rsp2 got=%h exp=509", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick(); tick();                                           // T+9
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b111_1100_1101) begin
      n_fail++; $display("FAIL arb_rsp3 got=%h exp=7cd", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick(); tick();
  endtask

  // Req0 alone, addr 1 len 3.
  task automatic test_single_burst();
    drive(2'b01, 8'd1, 4'd3, 8'd0, 4'd0);                     // T
    #1;
    n_checks++;
    if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL single_rdy got=%b exp=01", req_rdy); end
    tick();                                                   // T+1
    req_vld = 2'b00;
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr, busy} !== {1'b1, 8'd1, 1'b1}) begin
      n_fail++; $display("FAIL single_rom1 got=%h exp=203", {rom_rd_vld, rom_rd_addr, busy});
    end
    tick();                                                   // T+2
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h102) begin
      n_fail++; $display("FAIL single_rom2 got=%h exp=102", {rom_rd_vld, rom_rd_addr});
    end
    tick();                                                   // T+3
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h103) begin
      n_fail++; $display("FAIL single_rom3 got=%h exp=103", {rom_rd_vld, rom_rd_addr});
    end
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b100_0011_1111) begin
      n_fail++; $display("FAIL single_rsp1 got=%h exp=43f", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // T+4
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h003) begin
      n_fail++; $display("FAIL single_rom_hold got=%h exp=003", {rom_rd_vld, rom_rd_addr});
    end
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b100_1100_1100) begin
      n_fail++; $display("FAIL single_rsp2 got=%h exp=4cc", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // T+5
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b101_1100_1100) begin
      n_fail++; $display("FAIL single_rsp3 got=%h exp=5cc", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // T+6
    n_checks++;
    if ({rsp_vld, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_done got=%b exp=00", {rsp_vld, busy});
    end
  endtask

  // Req1 addr 19 len 3 wraps to 0, 1.
  task automatic test_wrap();
    drive(2'b10, 8'd0, 4'd0, 8'd19, 4'd3);                    // T
    #1;
    n_checks++;
    if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL wrap_rdy got=%b exp=10", req_rdy); end
    tick();                                                   // T+1
    req_vld = 2'b00;
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h113) begin
      n_fail++; $display("FAIL wrap_rom19 got=%h exp=113", {rom_rd_vld, rom_rd_addr});
    end
    tick();                                                   // T+2
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h100) begin
      n_fail++; $display("FAIL wrap_rom0 got=%h exp=100", {rom_rd_vld, rom_rd_addr});
    end
    tick();                                                   // T+3
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h101) begin
      n_fail++; $display("FAIL wrap_rom1 got=%h exp=101", {rom_rd_vld, rom_rd_addr});
    end
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b110_0001_0110) begin
      n_fail++; $display("FAIL wrap_rsp1 got=%h exp=616", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // T+4
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b110_0000_1001) begin
      n_fail++; $display("FAIL wrap_rsp2 got=%h exp=609", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // T+5
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b111_0011_1111) begin
      n_fail++; $display("FAIL wrap_rsp3 got=%h exp=73f", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();
  endtask

  // Req0 len 0: accept pulse only. The pointer still rotates to 1.
  // A withdrawn request is not accepted.
  task automatic test_zero_len();
    drive(2'b01, 8'd2, 4'd0, 8'd2, 4'd1);                     // T
    #1;
    n_checks++;
    if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL zero_rdy got=%b exp=01", req_rdy); end
    tick();                                                   // T+1
    n_checks++;
    if ({rom_rd_vld, busy, dbg_state} !== 3'b000) begin
      n_fail++; $display("FAIL zero_idle got=%b exp=000", {rom_rd_vld, busy, dbg_state});
    end
    drive(2'b11, 8'd2, 4'd1, 8'd2, 4'd1);
    #1;
    n_checks++;
    if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL zero_ptr got=%b exp=10", req_rdy); end
    req_vld = 2'b00;                                          // withdraw before the edge
    for (int i = 0; i < 3; i++) begin
      tick();                                                 // T+2..T+4
      n_checks++;
      if ({rom_rd_vld, rom_rd_addr, rsp_vld, busy} !== {1'b0, 8'd1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL zero_quiet[%0d] got=%h exp=004", i, {rom_rd_vld, rom_rd_addr, rsp_vld, busy});
      end
    end
  endtask

  // Reset during cycle T+2 of a len-5 burst, then a normal request.
  task automatic test_reset_mid_burst();
    drive(2'b01, 8'd2, 4'd5, 8'd0, 4'd1);                     // T
    #1;
    n_checks++;
    if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL rst_rdy got=%b exp=01", req_rdy); end
    tick();                                                   // T+1
    req_vld = 2'b00;
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h102) begin
      n_fail++; $display("FAIL rst_rom1 got=%h exp=102", {rom_rd_vld, rom_rd_addr});
    end
    tick();                                                   // T+2
    reset_n = 1'b0;
    tick();                                                   // T+3
    reset_n = 1'b1;
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr, rsp_vld, rsp_id, rsp_last, rsp_data, busy, req_rdy} !== 23'h0) begin
      n_fail++;
      $display("FAIL rst_outputs got=%h exp=000000",
               {rom_rd_vld, rom_rd_addr, rsp_vld, rsp_id, rsp_last, rsp_data, busy, req_rdy});
    end
    for (int i = 0; i < 3; i++) begin
      tick();                                                 // T+4..T+6
      n_checks++;
      if ({rom_rd_vld, rsp_vld, busy} !== 3'b000) begin
        n_fail++; $display("FAIL rst_quiet[%0d] got=%b exp=000", i, {rom_rd_vld, rsp_vld, busy});
      end
    end
    // The pointer went back to 0, so req0 wins the tie.
    drive(2'b11, 8'd3, 4'd2, 8'd0, 4'd1);                     // A
    #1;
    n_checks++;
    if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL rst_ptr got=%b exp=01", req_rdy); end
    tick();                                                   // A+1
    req_vld = 2'b00;
    n_checks++;
    if ({rom_rd_vld, rom_rd_addr} !== 9'h103) begin
      n_fail++; $display("FAIL rst_new_rom got=%h exp=103", {rom_rd_vld, rom_rd_addr});
    end
    tick(); tick();                                           // A+3
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b100_1100_1100) begin
      n_fail++; $display("FAIL rst_new_rsp1 got=%h exp=4cc", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // A+4
    n_checks++;
    if ({rsp_vld, rsp_id, rsp_last, rsp_data} !== 11'b101_1100_1101) begin
      n_fail++; $display("FAIL rst_new_rsp2 got=%h exp=5cd", {rsp_vld, rsp_id, rsp_last, rsp_data});
    end
    tick();                                                   // A+5
    n_checks++;
    if ({rsp_vld, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rst_new_done got=%b exp=00", {rsp_vld, busy});
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int i = 0; i < DATA_DEPTH; i++) rom_mem[i] = 8'hA0 + 8'(i);
    rom_mem[0]  = 8'h09;
    rom_mem[1]  = 8'h3F;
    rom_mem[2]  = 8'hCC;
    rom_mem[3]  = 8'hCC;
    rom_mem[4]  = 8'hCD;
    rom_mem[19] = 8'h16;

    test_reset();
    test_arbitration();
    test_single_burst();
    test_wrap();
    test_zero_len();
    test_reset_mid_burst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
